// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer.
package sipo_pkg;

  typedef enum logic {IDLE, RECV} rx_state_t;
  typedef enum logic {EMPTY, FULL} hold_state_t;

  // Bit-counter width; leaves room for a trailing parity bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sipo_if.sv
// Serial input, parallel output and status bundle of the SIPO deserializer.
interface sipo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             d;
  logic             shift_en;
  logic             sync;
  logic             ovr_clr;
  logic             pready;
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             perr;
  logic             overrun;
  logic             busy;

  modport master (
    output d, shift_en, sync, ovr_clr, pready,
    input  pdata, pvalid, perr, overrun, busy
  );

  modport slave (
    input  d, shift_en, sync, ovr_clr, pready,
    output pdata, pvalid, perr, overrun, busy
  );
endinterface

// File: rtl/sipo_hold_reg.sv
// One-deep valid/ready holding register; flags a drop when loaded while full and not draining.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             data_perr,
  input  logic             pready,
  output logic [WIDTH-1:0] pdata,
  output logic             perr,
  output logic             pvalid,
  output logic             drop
);

  hold_state_t      state_q;
  logic [WIDTH-1:0] pdata_q;
  logic             perr_q;
  logic             take;

  // A full register draining this cycle can take the new word without a bubble.
  assign take = load & ((state_q == EMPTY) | pready);
  assign drop = load & (state_q == FULL) & ~pready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= EMPTY;
      pdata_q <= '0;
      perr_q  <= 1'b0;
    end else if (take) begin
      state_q <= FULL;
      pdata_q <= data;
      perr_q  <= data_perr;
    end else if ((state_q == FULL) && pready) begin
      state_q <= EMPTY;
    end
  end

  assign pdata  = pdata_q;
  assign perr   = perr_q;
  assign pvalid = (state_q == FULL);

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer, MSB first, with a one-deep output register.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per word and report it on perr.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic clr_n,
  sipo_if.slave bus
);

`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = cnt_w(WIDTH);
  localparam int unsigned SW = FRAME - 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  rx_state_t        rx_q;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    shreg_q;
  logic [WIDTH-1:0] word;
  logic             word_perr;
  logic             final_bit;
  logic             drop;
  logic             overrun_q;

  // sync wins over completion: a strobe in the sync cycle starts a new frame.
  assign final_bit = bus.shift_en & ~bus.sync & (cnt_q == LAST);

`ifdef SIPO_PARITY_EN
  assign word      = shreg_q;
  assign word_perr = ^{shreg_q, bus.d};
`else
  assign word      = {shreg_q, bus.d};
  assign word_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rx_q    <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (bus.sync) begin
      rx_q    <= bus.shift_en ? RECV : IDLE;
      cnt_q   <= bus.shift_en ? CW'(1) : '0;
      shreg_q <= bus.shift_en ? SW'(bus.d) : '0;
    end else if (bus.shift_en) begin
      if (final_bit) begin
        rx_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        rx_q  <= RECV;
        cnt_q <= cnt_q + CW'(1);
      end
`ifdef SIPO_PARITY_EN
      if (!final_bit) shreg_q <= SW'({shreg_q, bus.d});
`else
      shreg_q <= SW'({shreg_q, bus.d});
`endif
    end
  end

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (final_bit),
    .data     (word),
    .data_perr(word_perr),
    .pready   (bus.pready),
    .pdata    (bus.pdata),
    .perr     (bus.perr),
    .pvalid   (bus.pvalid),
    .drop     (drop)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
  assign bus.busy    = (rx_q == RECV);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed and random checks of sipo_deserializer against a frame-queue reference model.
module tb_sipo_deserializer;

  localparam int unsigned WIDTH = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sipo_if #(.WIDTH(WIDTH)) bus ();

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the frame in progress plus the held word.
  bit               fq[$];
  logic [WIDTH-1:0] m_pdata;
  logic             m_valid;
  logic             m_perr;
  logic             m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_pdata = '0;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pdata"}, 32'(bus.pdata), 32'(m_pdata));
    chk({tag, "_pvalid"}, 32'(bus.pvalid), 32'(m_valid));
    chk({tag, "_perr"}, 32'(bus.perr), 32'(m_perr));
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(fq.size() != 0));
  endtask

  task automatic step(input logic d, input logic se, input logic sy, input logic oc,
                      input logic pr, input string tag);
    logic             done;
    logic             acc;
    logic             drop;
    logic             p;
    logic [WIDTH-1:0] w;
    bus.d = d; bus.shift_en = se; bus.sync = sy; bus.ovr_clr = oc; bus.pready = pr;
    done = 1'b0;
    p    = 1'b0;
    w    = '0;
    acc  = m_valid & pr;
    if (sy) fq.delete();
    if (se) fq.push_back(d);
    if (fq.size() == FRAME) begin
      for (int i = 0; i < int'(WIDTH); i++) w = {w[WIDTH-2:0], logic'(fq[i])};
`ifdef SIPO_PARITY_EN
      foreach (fq[i]) p ^= fq[i];
`endif
      fq.delete();
      done = 1'b1;
    end
    drop = done & m_valid & ~acc;
    if (done && !drop) begin
      m_pdata = w;
      m_perr  = p;
      m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic pr_all, input logic pr_last,
                           input logic oc_last, input string tag);
    bit b[$];
    for (int i = int'(WIDTH) - 1; i >= 0; i--) b.push_back(w[i]);
`ifdef SIPO_PARITY_EN
    b.push_back(^w);
`endif
    foreach (b[i]) begin
      if (i == b.size() - 1) step(b[i], 1'b1, 1'b0, oc_last, pr_last, tag);
      else step(b[i], 1'b1, 1'b0, 1'b0, pr_all, tag);
    end
  endtask

  initial begin
    bus.d = 0; bus.shift_en = 0; bus.sync = 0; bus.ovr_clr = 0; bus.pready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    clr_n = 1'b1;

    // 1: reset mid-frame, then 0xA5
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t1_pre");
    bus.shift_en = 1'b0;
    clr_n = 1'b0;
    #2;
    model_reset();
    check_all("t1_async_reset");
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0, "t1");
    chk("t1_pdata_a5", 32'(bus.pdata), 32'h0000_00A5);
    chk("t1_pvalid_set", 32'(bus.pvalid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t1_drain");

    // 2: back-to-back words with pready held high
    send_word(8'h3C, 1'b1, 1'b1, 1'b0, "t2a");
    chk("t2_first", 32'(bus.pdata), 32'h0000_003C);
    send_word(8'hC3, 1'b1, 1'b1, 1'b0, "t2b");
    chk("t2_second", 32'(bus.pdata), 32'h0000_00C3);
    chk("t2_no_overrun", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t2_drain");

    // 3: overrun while full, clear colliding with a new drop, then plain clear
    send_word(8'h11, 1'b0, 1'b0, 1'b0, "t3a");
    send_word(8'h22, 1'b0, 1'b0, 1'b0, "t3b");
    chk("t3_held", 32'(bus.pdata), 32'h0000_0011);
    chk("t3_overrun", 32'(bus.overrun), 32'h1);
    send_word(8'h33, 1'b0, 1'b0, 1'b1, "t3c");
    chk("t3_clr_vs_drop", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3_clr");
    chk("t3_cleared", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_drain");

    // 4: sync with a strobe restarts the frame using that bit
    for (int i = 0; i < 5; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0, 1'b0, "t4_pre");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t4_sync");
    for (int i = 0; i < int'(FRAME) - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_bits");
    chk("t4_pdata", 32'(bus.pdata), 32'h0000_0080);
    chk("t4_no_overrun", 32'(bus.overrun), 32'h0);

    // 5: pass-through on drain cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_empty");
    send_word(8'h55, 1'b0, 1'b0, 1'b0, "t5a");
    send_word(8'hAA, 1'b0, 1'b1, 1'b0, "t5b");
    chk("t5_pdata", 32'(bus.pdata), 32'h0000_00AA);
    chk("t5_pvalid", 32'(bus.pvalid), 32'h1);
    chk("t5_no_overrun", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_drain");

`ifdef SIPO_PARITY_EN
    // 6: good and bad parity on 0x07
    for (int i = 7; i >= 0; i--) step(1'(8'h07 >> i), 1'b1, 1'b0, 1'b0, 1'b0, "t6a");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6a_par");
    chk("t6_perr_good", 32'(bus.perr), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t6_drain");
    for (int i = 7; i >= 0; i--) step(1'(8'h07 >> i), 1'b1, 1'b0, 1'b0, 1'b0, "t6b");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t6b_par");
    chk("t6_perr_bad", 32'(bus.perr), 32'h1);
    chk("t6_pdata", 32'(bus.pdata), 32'h0000_0007);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(9) < 7), 1'($urandom_range(19) == 0),
           1'($urandom_range(19) == 0), 1'($urandom_range(1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
